// File: rtl/io_uart_pkg.sv
// Shared types and bit positions for the IO64/IO65 UART transmitter.
// Frame shape constants and the IO65 status word packer.
package io_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int IO64_DATA_LSB = 0;
  localparam int IO64_REQ_BIT  = 8;
  localparam int IO65_ACK_BIT  = 0;
  localparam int IO65_BUSY_BIT = 1;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
  localparam int BAUD_W         = 16;

  function automatic logic [15:0] io65_pack(
    input logic ack,
    input logic busy
  );
    logic [15:0] w;
    w = '0;
    w[IO65_ACK_BIT]  = ack;
    w[IO65_BUSY_BIT] = busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter for the UART transmitter.
// tick marks the last cycle of each CLK_DIV-cycle bit period.
module uart_baud_cnt
  import io_uart_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clear,
  output logic tick
);

  localparam logic [BAUD_W-1:0] LAST = BAUD_W'(CLK_DIV - 1);

  logic [BAUD_W-1:0] cnt_q;

  // Count 0..CLK_DIV-1, wrap on each bit boundary, hold at 0 when cleared.
  always_ff @(posedge CLK) begin
    if (!RESET_N || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/io64_uart_tx.sv
// IO64-driven 8N1 UART transmitter with toggle REQ/ACK handshake.
// Status (ACK, BUSY) is returned on the IO65 word.
module io64_uart_tx
  import io_uart_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] IO64_WORD,
  output logic [15:0] IO65_WORD,
  output logic        TXD
);

  tx_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        req_q, req_d;
  logic        ack_q, ack_d;
  logic        txd_q, txd_d;
  logic [15:0] io65_q;
  logic        tick;
  logic        io64_req;
  logic [7:0]  io64_data;
  logic        unused_hi;

  assign io64_req  = IO64_WORD[IO64_REQ_BIT];
  assign io64_data = IO64_WORD[IO64_DATA_LSB +: UART_DATA_BITS];
  assign unused_hi = ^IO64_WORD[15:9];

  uart_baud_cnt #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .clear  (state_q == IDLE),
    .tick   (tick)
  );

  // Next-state, shift register and handshake logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    req_d   = req_q;
    ack_d   = ack_q;
    unique case (state_q)
      IDLE: begin
        if (io64_req != req_q) begin
          shift_d = io64_data;
          req_d   = io64_req;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          ack_d   = req_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the upcoming cycle, from the next state.
  always_comb begin
    txd_d = 1'b1;
    unique case (1'b1)
      (state_d == START): txd_d = 1'b0;
      (state_d == DATA):  txd_d = shift_d[0];
      default:            txd_d = 1'b1;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      txd_q   <= 1'b1;
      io65_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      txd_q   <= txd_d;
      io65_q  <= io65_pack(ack_d, state_d != IDLE);
    end
  end

  assign TXD       = txd_q;
  assign IO65_WORD = io65_q;

endmodule
